cuckoo_l2_loader: RTL and testbench

// - Write-side companion of the L2 cuckoo lookup pipeline: inserts patterns into the shared index RAM (T1 bank 0, T2 bank 1) and the T3 entry RAM.
// - Computes the same T1/T2 hash as the lookup, allocates a T3 pointer, stores the entry, places the pointer by cuckoo displacement with a bounded kick count.
// - Sits between the host/config path and the RAM write ports; lookup_hold stalls the lookup (enable low) while tables change.

---
 rtl/cuckoo_l2_loader.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_cuckoo_l2_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cuckoo_l2_loader.sv
// Cuckoo insert engine: hashes a request, stores it in T3 and places its pointer in the T1/T2 index RAM by bounded displacement.
// Optional macro CUCKOO_LOADER_CLEAR_EN adds a clear_req input that zero-sweeps the index RAM and restarts pointer allocation.
module cuckoo_l2_loader #(
  parameter int MAX_KICKS = 16,
  parameter int IDX_AW    = 10,
  parameter int PTR_W     = 9,
  parameter int DATA_W    = 18
) (
  input  logic              i_clk,
  input  logic              i_rst,
`ifdef CUCKOO_LOADER_CLEAR_EN
  input  logic              i_clear_req,
`endif
  input  logic              i_ins_valid,
  output logic              o_ins_ready,
  input  logic [IDX_AW-1:0] i_ins_prehash_t1,
  input  logic [IDX_AW-1:0] i_ins_prehash_t2,
  input  logic [7:0]        i_ins_key,
  input  logic [DATA_W-1:0] i_ins_data,
  output logic [IDX_AW:0]   o_idx_addr,
  output logic              o_idx_we,
  output logic [PTR_W-1:0]  o_idx_din,
  input  logic [PTR_W-1:0]  i_idx_dout,
  output logic [PTR_W-1:0]  o_t3_addr,
  output logic              o_t3_we,
  output logic [DATA_W-1:0] o_t3_din,
  output logic              o_lookup_hold,
  output logic              o_done,
  output logic [1:0]        o_done_status,
  output logic [PTR_W-1:0]  o_done_ptr,
  output logic [PTR_W-1:0]  o_dropped_ptr
);

  localparam int KW = $clog2(MAX_KICKS + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_T3, S_RD1, S_WT1, S_EV1, S_RD2, S_WT2, S_EV2,
    S_KRD, S_KWT, S_KEV, S_DONE
`ifdef CUCKOO_LOADER_CLEAR_EN
    , S_CLR
`endif
  } state_t;

  function automatic logic [IDX_AW-1:0] f_hash(input logic [IDX_AW-1:0] p, input logic [7:0] k);
    logic [IDX_AW-1:0] sh_l;
    logic [IDX_AW-1:0] sh_r;
    sh_l = {p[IDX_AW-4:0], 3'b000};
    sh_r = {3'b000, p[IDX_AW-1:3]};
    return (sh_l + sh_r + IDX_AW'(k)) ^ p;
  endfunction

  state_t              r_state, w_state;
  logic [IDX_AW-1:0]   r_h1, w_h1, r_h2, w_h2, r_addr, w_addr;
  logic [DATA_W-1:0]   r_data, w_data;
  logic [PTR_W-1:0]    r_next_ptr, w_next_ptr, r_cur_ptr, w_cur_ptr;
  logic [PTR_W-1:0]    r_dout, w_dout, r_done_ptr, w_done_ptr, r_dropped, w_dropped;
  logic                r_side, w_side;
  logic [KW-1:0]       r_kicks, w_kicks, w_kicks_inc;
  logic [1:0]          r_status, w_status;
  logic [2*IDX_AW-1:0] r_shadow [0:(1<<PTR_W)-1];
  logic [2*IDX_AW-1:0] w_shadow_ent;
`ifdef CUCKOO_LOADER_CLEAR_EN
  logic [IDX_AW:0]     r_clr_cnt, w_clr_cnt;
`endif

  logic                r_ins_ready, w_ins_ready, r_hold, r_done, w_done;
  logic [IDX_AW:0]     r_idx_addr, w_idx_addr;
  logic                r_idx_we, w_idx_we, r_t3_we, w_t3_we;
  logic [PTR_W-1:0]    r_idx_din, w_idx_din, r_t3_addr, w_t3_addr;
  logic [DATA_W-1:0]   r_t3_din, w_t3_din;
  logic [1:0]          r_o_status;
  logic [PTR_W-1:0]    r_o_done_ptr, r_o_dropped;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state;
  end

  // Next-state and next-datapath decode
  always_comb begin
    w_state     = r_state;
    w_h1        = r_h1;
    w_h2        = r_h2;
    w_data      = r_data;
    w_next_ptr  = r_next_ptr;
    w_cur_ptr   = r_cur_ptr;
    w_side      = r_side;
    w_addr      = r_addr;
    w_kicks     = r_kicks;
    w_dout      = r_dout;
    w_status    = r_status;
    w_done_ptr  = r_done_ptr;
    w_dropped   = r_dropped;
`ifdef CUCKOO_LOADER_CLEAR_EN
    w_clr_cnt   = r_clr_cnt;
`endif
    w_shadow_ent = r_shadow[r_dout];
    w_kicks_inc  = r_kicks + KW'(1);
    case (r_state)
      S_IDLE: begin
`ifdef CUCKOO_LOADER_CLEAR_EN
        if (i_clear_req) begin
          w_state   = S_CLR;
          w_clr_cnt = {(IDX_AW+1){1'b0}};
        end else
`endif
        if (i_ins_valid) begin
          w_h1      = f_hash(i_ins_prehash_t1, i_ins_key);
          w_h2      = f_hash(i_ins_prehash_t2, i_ins_key);
          w_data    = i_ins_data;
          w_kicks   = {KW{1'b0}};
          w_dropped = {PTR_W{1'b0}};
          // A wrapped allocator means every pointer has been handed out
          if (r_next_ptr == {PTR_W{1'b0}}) begin
            w_state    = S_DONE;
            w_status   = 2'b10;
            w_done_ptr = {PTR_W{1'b0}};
          end else begin
            w_state    = S_WR_T3;
            w_cur_ptr  = r_next_ptr;
            w_done_ptr = r_next_ptr;
            w_next_ptr = r_next_ptr + PTR_W'(1);
          end
        end else begin
          w_state = S_IDLE;
        end
      end
      S_WR_T3: w_state = S_RD1;
      S_RD1:   w_state = S_WT1;
      S_WT1:   begin w_dout = i_idx_dout; w_state = S_EV1; end
      S_EV1: begin
        if (r_dout == {PTR_W{1'b0}}) begin
          w_state  = S_DONE;
          w_status = 2'b00;
        end else begin
          w_state = S_RD2;
        end
      end
      S_RD2:   w_state = S_WT2;
      S_WT2:   begin w_dout = i_idx_dout; w_state = S_EV2; end
      S_EV2: begin
        if (r_dout == {PTR_W{1'b0}}) begin
          w_state  = S_DONE;
          w_status = 2'b00;
        end else begin
          w_state = S_KRD;
          w_side  = 1'b0;
          w_addr  = r_h1;
        end
      end
      S_KRD:   w_state = S_KWT;
      S_KWT:   begin w_dout = i_idx_dout; w_state = S_KEV; end
      S_KEV: begin
        if (r_dout == {PTR_W{1'b0}}) begin
          w_state  = S_DONE;
          w_status = 2'b00;
        end else if (w_kicks_inc == KW'(MAX_KICKS)) begin
          w_kicks   = w_kicks_inc;
          w_state   = S_DONE;
          w_status  = 2'b01;
          w_dropped = r_dout;
        end else begin
          // Victim moves to its alternate slot on the opposite bank
          w_kicks   = w_kicks_inc;
          w_cur_ptr = r_dout;
          w_side    = ~r_side;
          w_addr    = r_side ? w_shadow_ent[2*IDX_AW-1:IDX_AW] : w_shadow_ent[IDX_AW-1:0];
          w_state   = S_KRD;
        end
      end
      S_DONE:  w_state = S_IDLE;
`ifdef CUCKOO_LOADER_CLEAR_EN
      S_CLR: begin
        w_clr_cnt = r_clr_cnt + {{IDX_AW{1'b0}}, 1'b1};
        if (&r_clr_cnt) begin
          w_state    = S_DONE;
          w_next_ptr = {{(PTR_W-1){1'b0}}, 1'b1};
          w_status   = 2'b00;
          w_done_ptr = {PTR_W{1'b0}};
          w_dropped  = {PTR_W{1'b0}};
        end else begin
          w_state = S_CLR;
        end
      end
`endif
      default: w_state = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the RAM ports are driven from flops
  always_comb begin
    w_ins_ready = (w_state == S_IDLE);
    w_done      = (w_state == S_DONE);
    w_idx_addr  = {(IDX_AW+1){1'b0}};
    w_idx_we    = 1'b0;
    w_idx_din   = {PTR_W{1'b0}};
    w_t3_we     = 1'b0;
    w_t3_addr   = {PTR_W{1'b0}};
    w_t3_din    = {DATA_W{1'b0}};
    case (w_state)
      S_WR_T3: begin
        w_t3_we   = 1'b1;
        w_t3_addr = w_cur_ptr;
        w_t3_din  = w_data;
      end
      S_RD1, S_WT1: w_idx_addr = {1'b0, w_h1};
      S_EV1: begin
        w_idx_addr = {1'b0, w_h1};
        w_idx_we   = (w_dout == {PTR_W{1'b0}});
        w_idx_din  = w_cur_ptr;
      end
      S_RD2, S_WT2: w_idx_addr = {1'b1, w_h2};
      S_EV2: begin
        w_idx_addr = {1'b1, w_h2};
        w_idx_we   = (w_dout == {PTR_W{1'b0}});
        w_idx_din  = w_cur_ptr;
      end
      S_KRD, S_KWT: w_idx_addr = {w_side, w_addr};
      S_KEV: begin
        w_idx_addr = {w_side, w_addr};
        w_idx_we   = 1'b1;
        w_idx_din  = w_cur_ptr;
      end
`ifdef CUCKOO_LOADER_CLEAR_EN
      S_CLR: begin
        w_idx_addr = w_clr_cnt;
        w_idx_we   = 1'b1;
      end
`endif
      default: w_idx_we = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_h1 <= {IDX_AW{1'b0}};        r_h2 <= {IDX_AW{1'b0}};
      r_addr <= {IDX_AW{1'b0}};      r_data <= {DATA_W{1'b0}};
      r_next_ptr <= {{(PTR_W-1){1'b0}}, 1'b1};
      r_cur_ptr <= {PTR_W{1'b0}};    r_dout <= {PTR_W{1'b0}};
      r_done_ptr <= {PTR_W{1'b0}};   r_dropped <= {PTR_W{1'b0}};
      r_side <= 1'b0;                r_kicks <= {KW{1'b0}};
      r_status <= 2'b00;
`ifdef CUCKOO_LOADER_CLEAR_EN
      r_clr_cnt <= {(IDX_AW+1){1'b0}};
`endif
      r_ins_ready <= 1'b1;           r_hold <= 1'b0;
      r_done <= 1'b0;                r_idx_addr <= {(IDX_AW+1){1'b0}};
      r_idx_we <= 1'b0;              r_idx_din <= {PTR_W{1'b0}};
      r_t3_we <= 1'b0;               r_t3_addr <= {PTR_W{1'b0}};
      r_t3_din <= {DATA_W{1'b0}};    r_o_status <= 2'b00;
      r_o_done_ptr <= {PTR_W{1'b0}}; r_o_dropped <= {PTR_W{1'b0}};
    end else begin
      r_h1 <= w_h1;                  r_h2 <= w_h2;
      r_addr <= w_addr;              r_data <= w_data;
      r_next_ptr <= w_next_ptr;      r_cur_ptr <= w_cur_ptr;
      r_dout <= w_dout;              r_done_ptr <= w_done_ptr;
      r_dropped <= w_dropped;        r_side <= w_side;
      r_kicks <= w_kicks;            r_status <= w_status;
`ifdef CUCKOO_LOADER_CLEAR_EN
      r_clr_cnt <= w_clr_cnt;
`endif
      r_ins_ready <= w_ins_ready;    r_hold <= ~w_ins_ready;
      r_done <= w_done;              r_idx_addr <= w_idx_addr;
      r_idx_we <= w_idx_we;          r_idx_din <= w_idx_din;
      r_t3_we <= w_t3_we;            r_t3_addr <= w_t3_addr;
      r_t3_din <= w_t3_din;
      if (w_done) begin
        r_o_status   <= w_status;
        r_o_done_ptr <= w_done_ptr;
        r_o_dropped  <= w_dropped;
      end else begin
        r_o_status   <= r_o_status;
        r_o_done_ptr <= r_o_done_ptr;
        r_o_dropped  <= r_o_dropped;
      end
    end
  end

  // Per-pointer {h1,h2} record used to find a victim's alternate slot
  always_ff @(posedge i_clk) begin
    if (r_state == S_WR_T3) r_shadow[r_cur_ptr] <= {r_h1, r_h2};
  end

  assign o_ins_ready   = r_ins_ready;
  assign o_lookup_hold = r_hold;
  assign o_done        = r_done;
  assign o_idx_addr    = r_idx_addr;
  assign o_idx_we      = r_idx_we;
  assign o_idx_din     = r_idx_din;
  assign o_t3_we       = r_t3_we;
  assign o_t3_addr     = r_t3_addr;
  assign o_t3_din      = r_t3_din;
  assign o_done_status = r_o_status;
  assign o_done_ptr    = r_o_done_ptr;
  assign o_dropped_ptr = r_o_dropped;

endmodule

// File: tb/tb_cuckoo_l2_loader.sv
// Directed bench for cuckoo_l2_loader with behavioural index/T3 RAMs; built with MAX_KICKS=4.
module tb_cuckoo_l2_loader;
  localparam int IDX_AW = 10, PTR_W = 9, DATA_W = 18, MAXK = 4;

  logic clk = 1'b0;
  logic rst;
  logic ins_valid;
  logic ins_ready;
  logic [IDX_AW-1:0] p1, p2;
  logic [7:0] key;
  logic [DATA_W-1:0] data;
  logic [IDX_AW:0] idx_addr;
  logic idx_we;
  logic [PTR_W-1:0] idx_din;
  logic [PTR_W-1:0] idx_dout = '0;
  logic [PTR_W-1:0] t3_addr;
  logic t3_we;
  logic [DATA_W-1:0] t3_din;
  logic hold, done;
  logic [1:0] done_status;
  logic [PTR_W-1:0] done_ptr, dropped_ptr;
`ifdef CUCKOO_LOADER_CLEAR_EN
  logic clear_req;
`endif

  logic [PTR_W-1:0]  idx_mem [0:2047] = '{default: '0};
  logic [DATA_W-1:0] t3_mem  [0:511]  = '{default: '0};
  int n_idx_wr = 0, n_t3_wr = 0, n_done = 0;
  int checks = 0, errors = 0;

  cuckoo_l2_loader #(.MAX_KICKS(MAXK), .IDX_AW(IDX_AW), .PTR_W(PTR_W), .DATA_W(DATA_W)) dut (
    .i_clk(clk), .i_rst(rst),
`ifdef CUCKOO_LOADER_CLEAR_EN
    .i_clear_req(clear_req),
`endif
    .i_ins_valid(ins_valid), .o_ins_ready(ins_ready),
    .i_ins_prehash_t1(p1), .i_ins_prehash_t2(p2), .i_ins_key(key), .i_ins_data(data),
    .o_idx_addr(idx_addr), .o_idx_we(idx_we), .o_idx_din(idx_din), .i_idx_dout(idx_dout),
    .o_t3_addr(t3_addr), .o_t3_we(t3_we), .o_t3_din(t3_din),
    .o_lookup_hold(hold), .o_done(done), .o_done_status(done_status),
    .o_done_ptr(done_ptr), .o_dropped_ptr(dropped_ptr));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (idx_we) begin
      idx_mem[idx_addr] <= idx_din;
      n_idx_wr <= n_idx_wr + 1;
    end
    idx_dout <= idx_mem[idx_addr];
    if (t3_we) begin
      t3_mem[t3_addr] <= t3_din;
      n_t3_wr <= n_t3_wr + 1;
    end
    if (done) n_done <= n_done + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_insert(input logic [9:0] a1, input logic [9:0] a2, input logic [7:0] k,
                           input logic [17:0] d, output logic [1:0] st, output logic [8:0] ptr,
                           output logic [8:0] drop, output int nidx, output int nt3);
    int s_idx, s_t3, w;
    w = 0;
    while (!ins_ready && w < 100) begin @(negedge clk); w++; end
    chk("ready_before_insert", ins_ready, 1);
    p1 = a1; p2 = a2; key = k; data = d;
    s_idx = n_idx_wr; s_t3 = n_t3_wr;
    ins_valid = 1'b1;
    @(negedge clk);
    ins_valid = 1'b0;
    chk("hold_while_busy", {hold, ins_ready}, 2'b10);
    w = 0;
    while (!done && w < 200) begin @(negedge clk); w++; end
    chk("done_seen", done, 1);
    st = done_status; ptr = done_ptr; drop = dropped_ptr;
    nidx = n_idx_wr - s_idx; nt3 = n_t3_wr - s_t3;
    @(negedge clk);
  endtask

  typedef struct {
    logic [9:0] a1, a2; logic [7:0] k; logic [17:0] d;
    logic [1:0] st; logic [8:0] ptr, drop; int nidx; logic [10:0] caddr; logic [8:0] cval;
  } vec_t;
  vec_t vecs [8];

  initial begin
    logic [1:0] st;
    logic [8:0] ptr, drop;
    int nidx, nt3, bad, d0;

    // Kick-limit cycle at index 2: T1[5]=1,T2[12]=2 -> 3 displaces 1,1 displaces 2,2 displaces 3,3 displaces 1
    vecs[0] = '{10'd0, 10'd1, 8'h05, 18'h1A5A1, 2'b00, 9'd1, 9'd0, 1, 11'd5,    9'd1};
    vecs[1] = '{10'd0, 10'd1, 8'h05, 18'h2B0B2, 2'b00, 9'd2, 9'd0, 1, 11'd1036, 9'd2};
    vecs[2] = '{10'd0, 10'd1, 8'h05, 18'h3C0C3, 2'b01, 9'd3, 9'd1, 4, 11'd5,    9'd2};
    vecs[3] = '{10'd0, 10'd1, 8'h20, 18'h04444, 2'b00, 9'd4, 9'd0, 1, 11'd32,   9'd4};
    vecs[4] = '{10'd0, 10'd2, 8'h20, 18'h05555, 2'b00, 9'd5, 9'd0, 1, 11'd1074, 9'd5};
    vecs[5] = '{10'd0, 10'd2, 8'h20, 18'h06666, 2'b00, 9'd6, 9'd0, 2, 11'd1065, 9'd4};
    vecs[6] = '{10'h3FF, 10'h155, 8'hA5, 18'h07777, 2'b00, 9'd7, 9'd0, 1, 11'd739,  9'd7};
    vecs[7] = '{10'h3FF, 10'h155, 8'hA5, 18'h08888, 2'b00, 9'd8, 9'd0, 1, 11'd1570, 9'd8};

    rst = 1'b1; ins_valid = 1'b0; p1 = '0; p2 = '0; key = '0; data = '0;
`ifdef CUCKOO_LOADER_CLEAR_EN
    clear_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_ready_hold_done", {ins_ready, hold, done}, 3'b100);
    chk("reset_we", {idx_we, t3_we}, 2'b00);
    chk("reset_status_ptrs", {done_status, done_ptr, dropped_ptr, idx_addr}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_insert(vecs[i].a1, vecs[i].a2, vecs[i].k, vecs[i].d, st, ptr, drop, nidx, nt3);
      chk($sformatf("v%0d_status", i), st, vecs[i].st);
      chk($sformatf("v%0d_done_ptr", i), ptr, vecs[i].ptr);
      chk($sformatf("v%0d_dropped", i), drop, vecs[i].drop);
      chk($sformatf("v%0d_idx_writes", i), nidx, vecs[i].nidx);
      chk($sformatf("v%0d_t3_writes", i), nt3, 1);
      chk($sformatf("v%0d_t3_data", i), t3_mem[vecs[i].ptr], vecs[i].d);
      chk($sformatf("v%0d_idx_slot", i), idx_mem[vecs[i].caddr], vecs[i].cval);
    end
    chk("cycle_t2_12", idx_mem[1036], 3);
    chk("kick_t1_32", idx_mem[32], 6);

    // Abort in KICK WT: same keys as vector 0 force displacement
    while (!ins_ready) @(negedge clk);
    p1 = 10'd0; p2 = 10'd1; key = 8'h05; data = 18'h0ABCD;
    d0 = n_done;
    ins_valid = 1'b1;
    @(posedge clk);
    #1 ins_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("kwt_addr_hold", {hold, idx_we, idx_addr}, {1'b1, 1'b0, 11'd5});
    rst = 1'b1;
    #1;
    chk("abort_ready_hold", {ins_ready, hold, done, idx_we, t3_we}, 5'b10000);
    chk("abort_addr", idx_addr, 0);
    @(posedge clk);
    #1;
    chk("abort_held", {ins_ready, hold, idx_addr}, {2'b10, 11'd0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);

    do_insert(10'd0, 10'd0, 8'h77, 18'h11111, st, ptr, drop, nidx, nt3);
    chk("post_reset_ptr", ptr, 1);
    chk("post_reset_status", st, 0);
    chk("post_reset_slot", idx_mem[119], 1);

    bad = 0;
    for (int i = 2; i < 512; i++) begin
      do_insert(10'(i), ~10'(i), 8'(i * 7), 18'(i), st, ptr, drop, nidx, nt3);
      if (ptr !== 9'(i) || nt3 != 1) bad++;
    end
    chk("fill_ptrs", bad, 0);

    do_insert(10'd5, 10'd6, 8'h01, 18'h3FFFF, st, ptr, drop, nidx, nt3);
    chk("full_status", st, 2);
    chk("full_ptr_drop", {ptr, drop}, 0);
    chk("full_writes", nidx + nt3, 0);
    do_insert(10'd7, 10'd8, 8'h02, 18'h00001, st, ptr, drop, nidx, nt3);
    chk("full_sticky", {st, ptr}, {2'b10, 9'd0});

`ifdef CUCKOO_LOADER_CLEAR_EN
    d0 = n_idx_wr;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    chk("clear_hold", hold, 1);
    bad = 0;
    while (!done && bad < 2200) begin @(negedge clk); bad++; end
    chk("clear_done", done, 1);
    chk("clear_writes", n_idx_wr - d0, 2048);
    chk("clear_status", {done_status, done_ptr}, 0);
    @(negedge clk);
    chk("clear_zeroed", idx_mem[5] | idx_mem[1036] | idx_mem[2047], 0);
    do_insert(10'd0, 10'd1, 8'h05, 18'h12345, st, ptr, drop, nidx, nt3);
    chk("clear_next_ptr", ptr, 1);
    chk("clear_next_status", st, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
